xillybus_lite_regbank: RTL

- User-side responder on the Xillybus Lite register interface. The Lite core drives address, data, strobes and read/write enables; this block answers them.
- Contents: an ID register, a scratch register, a control/status pair, a one-shot/auto-reload down-counter timer with interrupt, a clear-on-read event counter, and a small word-addressed RAM.
- It sits in the user logic next to the Lite core pins and is the reference peripheral the host driver talks to.

---
 rtl/xillybus_lite_regbank.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/xillybus_lite_regbank.sv
// Xillybus Lite user-side register bank: ID, scratch, control/status, down-counter
// timer with interrupt, clear-on-read event counter and a small byte-writable RAM.
module xillybus_lite_regbank #(
   parameter logic [31:0] ID_VALUE       = 32'h584C5245,
   parameter int          RAM_DEPTH_LOG2 = 4
) (
   input  logic        user_clk,
   input  logic        user_rst_n,
   input  logic        user_wren,
   input  logic [3:0]  user_wstrb,
   input  logic        user_rden,
   input  logic [31:0] user_addr,
   input  logic [31:0] user_wr_data,
   output logic [31:0] user_rd_data,
   output logic        user_irq
);
   localparam int RAM_WORDS = 1 << RAM_DEPTH_LOG2;

   localparam logic [9:0] OFF_ID      = 10'd0;
   localparam logic [9:0] OFF_SCRATCH = 10'd1;
   localparam logic [9:0] OFF_CTRL    = 10'd2;
   localparam logic [9:0] OFF_STATUS  = 10'd3;
   localparam logic [9:0] OFF_LOAD    = 10'd4;
   localparam logic [9:0] OFF_COUNT   = 10'd5;
   localparam logic [9:0] OFF_EVENT   = 10'd6;

   logic [31:0] ram [RAM_WORDS];
   logic [31:0] scratch;
   logic [31:0] timer_load;
   logic [31:0] timer_count;
   logic [31:0] event_count;
   logic [31:0] rd_value;
   logic [2:0]  ctrl;
   logic        pending;

   logic                      is_ram;
   logic [9:0]                reg_off;
   logic [RAM_DEPTH_LOG2-1:0] ram_idx;
   logic                      wr_reg;
   logic                      wr_scratch;
   logic                      wr_ctrl;
   logic                      wr_load;
   logic                      w1c;
   logic                      rd_event;
   logic                      timer_start;
   logic                      expiry;
   logic                      running;
   logic                      unused_addr_bits;

   assign is_ram           = user_addr[12];
   assign reg_off          = user_addr[11:2];
   assign ram_idx          = user_addr[2 +: RAM_DEPTH_LOG2];
   assign unused_addr_bits = ^{user_addr[31:13], user_addr[1:0]};

   assign wr_reg      = user_wren && !is_ram;
   assign wr_scratch  = wr_reg && (reg_off == OFF_SCRATCH);
   assign wr_ctrl     = wr_reg && (reg_off == OFF_CTRL) && user_wstrb[0];
   assign wr_load     = wr_reg && (reg_off == OFF_LOAD);
   assign w1c         = wr_reg && (reg_off == OFF_STATUS) && user_wstrb[0] && user_wr_data[0];
   assign rd_event    = user_rden && !is_ram && (reg_off == OFF_EVENT);
   assign timer_start = wr_ctrl && !ctrl[0] && user_wr_data[0];
   assign running     = ctrl[0] && (timer_count != 32'd0);
   assign expiry      = ctrl[0] && (timer_count == 32'd1);

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
      logic [31:0] res;
      res = old_val;
      for (int i = 0; i < 4; i++) begin
         if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
      end
      return res;
   endfunction

   // Read mux sees pre-edge state, so a same-cycle write is not visible to the read.
   always_comb begin
      rd_value = 32'd0;
      if (is_ram) begin
         rd_value = ram[ram_idx];
      end else begin
         case (reg_off)
            OFF_ID:      rd_value = ID_VALUE;
            OFF_SCRATCH: rd_value = scratch;
            OFF_CTRL:    rd_value = {29'd0, ctrl};
            OFF_STATUS:  rd_value = {30'd0, running, pending};
            OFF_LOAD:    rd_value = timer_load;
            OFF_COUNT:   rd_value = timer_count;
            OFF_EVENT:   rd_value = event_count;
            default:     rd_value = 32'd0;
         endcase
      end
   end

   always_ff @(posedge user_clk) begin
      if (user_rst_n && user_wren && is_ram) begin
         for (int i = 0; i < 4; i++) begin
            if (user_wstrb[i]) ram[ram_idx][8*i +: 8] <= user_wr_data[8*i +: 8];
         end
      end
   end

   always_ff @(posedge user_clk) begin
      if (!user_rst_n) begin
         scratch      <= 32'd0;
         ctrl         <= 3'd0;
         pending      <= 1'b0;
         timer_load   <= 32'd0;
         timer_count  <= 32'd0;
         event_count  <= 32'd0;
         user_rd_data <= 32'd0;
         user_irq     <= 1'b0;
      end else begin
         if (wr_scratch) scratch <= merge_bytes(scratch, user_wr_data, user_wstrb);
         if (wr_ctrl)    ctrl <= user_wr_data[2:0];
         if (wr_load)    timer_load <= merge_bytes(timer_load, user_wr_data, user_wstrb);

         if (timer_start) begin
            timer_count <= timer_load;
         end else if (ctrl[0] && (timer_count > 32'd1)) begin
            timer_count <= timer_count - 32'd1;
         end else if (expiry) begin
            timer_count <= ctrl[2] ? timer_load : 32'd0;
         end

         // An expiry wins over a same-cycle W1C so no event is lost.
         if (expiry) begin
            pending <= 1'b1;
         end else if (w1c) begin
            pending <= 1'b0;
         end

         if (rd_event) begin
            event_count <= expiry ? 32'd1 : 32'd0;
         end else if (expiry && (event_count != 32'hFFFF_FFFF)) begin
            event_count <= event_count + 32'd1;
         end

         user_irq <= pending && ctrl[1];
         if (user_rden) user_rd_data <= rd_value;
      end
   end
endmodule
